// File: rtl/cmd_dispatch_pkg.sv
// cmd_dispatch shared types: opcodes, FSM states, response bytes.
// Optional command watchdog is enabled by defining CMD_WDOG_EN.
package cmd_dispatch_pkg;

    typedef enum logic [7:0] {
        SET_PTCH  = 8'h02,
        SET_ROLL  = 8'h03,
        SET_YAW   = 8'h04,
        SET_THRST = 8'h05,
        CALIBRATE = 8'h06,
        EMER_LAND = 8'h07,
        MTRS_OFF  = 8'h08
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        RAMP,
        CAL,
        SEND,
        WAIT_SENT
    } state_t;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_NAK = 8'hEE;

    function automatic logic op_known(input logic [7:0] c);
        return (c >= 8'(SET_PTCH)) && (c <= 8'(MTRS_OFF));
    endfunction

endpackage

// File: rtl/cmd_dispatch_if.sv
// Command/response handshake between the UART wrapper (master)
// and the command dispatcher (slave).
interface cmd_dispatch_if;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic        snd_resp;
    logic [7:0]  resp;
    logic        resp_sent;

    modport master (
        output cmd_rdy, cmd, data, resp_sent,
        input  clr_cmd_rdy, snd_resp, resp
    );

    modport slave (
        input  cmd_rdy, cmd, data, resp_sent,
        output clr_cmd_rdy, snd_resp, resp
    );
endinterface

// File: rtl/cmd_dispatch_timer.sv
// dispatch_timer: up-counter with clear, enable and a terminal-count
// flag; it stops at the terminal count until cleared.
module dispatch_timer #(
    parameter int           W  = 25,
    parameter logic [W-1:0] TC = '1
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    logic [W-1:0] r_cnt;

    assign o_tc = (r_cnt == TC);

    // clear has priority; count while enabled, saturate at TC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/cmd_dispatch.sv
// cmd_dispatch: consumes UART commands, drives flight setpoints and
// calibration, returns one response byte per command. Macro: CMD_WDOG_EN.
module cmd_dispatch
    import cmd_dispatch_pkg::*;
#(
    parameter logic [24:0] RAMP_CYC = 25'h1000000
`ifdef CMD_WDOG_EN
    , parameter logic [25:0] WDOG_CYC = 26'h3FFFFFF
`endif
)(
    input  logic          clk,
    input  logic          rst_n,
    cmd_dispatch_if.slave bus,
    input  logic          i_cal_done,
    output logic [15:0]   o_d_ptch,
    output logic [15:0]   o_d_roll,
    output logic [15:0]   o_d_yaw,
    output logic [8:0]    o_thrst,
    output logic          o_strt_cal,
    output logic          o_inertial_cal,
    output logic          o_motors_off
);
    state_t      r_state;
    state_t      w_nxt;
    logic        w_take;
    logic        w_is_cal;
    logic        w_ramp_tc;
    logic        w_snd;
    logic        w_strt;
    logic        w_cal_end;
    opcode_t     w_op;
    logic [15:0] r_ptch;
    logic [15:0] r_roll;
    logic [15:0] r_yaw;
    logic [8:0]  r_thrst;
    logic        r_motors_off;
    logic        r_inertial;
    logic        r_strt;
    logic        r_snd;
    logic [7:0]  r_resp;

    assign w_take          = (r_state == IDLE) && bus.cmd_rdy;
    assign w_op            = opcode_t'(bus.cmd);
    assign w_is_cal        = w_take && (bus.cmd == 8'(CALIBRATE));
    assign bus.clr_cmd_rdy = w_take;
    assign bus.snd_resp    = r_snd;
    assign bus.resp        = r_resp;
    assign o_d_ptch        = r_ptch;
    assign o_d_roll        = r_roll;
    assign o_d_yaw         = r_yaw;
    assign o_thrst         = r_thrst;
    assign o_strt_cal      = r_strt;
    assign o_inertial_cal  = r_inertial;
    assign o_motors_off    = r_motors_off;

    dispatch_timer #(
        .W  (25),
        .TC (RAMP_CYC - 25'd1)
    ) u_ramp (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_is_cal),
        .i_en  (r_state == RAMP),
        .o_tc  (w_ramp_tc)
    );

`ifdef CMD_WDOG_EN
    logic w_wdog_tc;
    logic w_wdog_trip;

    dispatch_timer #(
        .W  (26),
        .TC (WDOG_CYC)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_take),
        .i_en  (1'b1),
        .o_tc  (w_wdog_tc)
    );

    assign w_wdog_trip = w_wdog_tc && !r_motors_off
                         && (r_state == IDLE);
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // next state and single-cycle strobes
    always_comb begin
        w_nxt     = r_state;
        w_snd     = 1'b0;
        w_strt    = 1'b0;
        w_cal_end = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_nxt = w_is_cal ? RAMP : SEND;
                end
            end
            RAMP: begin
                if (w_ramp_tc) begin
                    w_strt = 1'b1;
                    w_nxt  = CAL;
                end
            end
            CAL: begin
                if (i_cal_done) begin
                    w_cal_end = 1'b1;
                    w_nxt     = SEND;
                end
            end
            SEND: begin
                w_snd = 1'b1;
                w_nxt = WAIT_SENT;
            end
            WAIT_SENT: begin
                if (bus.resp_sent) begin
                    w_nxt = IDLE;
                end
            end
            default: begin
                w_nxt = IDLE;
            end
        endcase
    end

    // setpoints, calibration flags and the response byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptch       <= '0;
            r_roll       <= '0;
            r_yaw        <= '0;
            r_thrst      <= '0;
            r_motors_off <= 1'b1;
            r_inertial   <= 1'b0;
            r_strt       <= 1'b0;
            r_snd        <= 1'b0;
            r_resp       <= 8'h00;
        end else begin
            r_snd  <= w_snd;
            r_strt <= w_strt;
            if (w_strt) begin
                r_inertial <= 1'b1;
            end
            if (w_cal_end) begin
                r_inertial <= 1'b0;
                r_resp     <= RESP_ACK;
            end
            if (w_take) begin
                case (w_op)
                    SET_PTCH:  r_ptch       <= bus.data;
                    SET_ROLL:  r_roll       <= bus.data;
                    SET_YAW:   r_yaw        <= bus.data;
                    SET_THRST: r_thrst      <= bus.data[8:0];
                    CALIBRATE: r_motors_off <= 1'b0;
                    EMER_LAND: begin
                        r_ptch  <= '0;
                        r_roll  <= '0;
                        r_yaw   <= '0;
                        r_thrst <= '0;
                    end
                    MTRS_OFF:  r_motors_off <= 1'b1;
                    default: ;
                endcase
                if (!w_is_cal) begin
                    r_resp <= op_known(bus.cmd) ? RESP_ACK : RESP_NAK;
                end
            end
`ifdef CMD_WDOG_EN
            else if (w_wdog_trip) begin
                r_ptch  <= '0;
                r_roll  <= '0;
                r_yaw   <= '0;
                r_thrst <= '0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_cmd_dispatch.sv
// tb_cmd_dispatch: directed plan plus random command stream checked
// against a behavioural setpoint/response model.
module tb_cmd_dispatch;
    localparam int RAMP = 8;

    logic        clk;
    logic        rst_n;
    logic        cal_done;
    logic [15:0] d_ptch;
    logic [15:0] d_roll;
    logic [15:0] d_yaw;
    logic [8:0]  thrst;
    logic        strt_cal;
    logic        inertial_cal;
    logic        motors_off;

    int n_chk;
    int n_err;

    logic [15:0] m_p;
    logic [15:0] m_r;
    logic [15:0] m_y;
    logic [8:0]  m_t;
    logic        m_off;

    cmd_dispatch_if u_if ();

    cmd_dispatch #(
        .RAMP_CYC (25'(RAMP))
`ifdef CMD_WDOG_EN
        , .WDOG_CYC (26'd16)
`endif
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (u_if.slave),
        .i_cal_done     (cal_done),
        .o_d_ptch       (d_ptch),
        .o_d_roll       (d_roll),
        .o_d_yaw        (d_yaw),
        .o_thrst        (thrst),
        .o_strt_cal     (strt_cal),
        .o_inertial_cal (inertial_cal),
        .o_motors_off   (motors_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("ptch", 32'(d_ptch), 32'(m_p));
        check("roll", 32'(d_roll), 32'(m_r));
        check("yaw", 32'(d_yaw), 32'(m_y));
        check("thrst", 32'(thrst), 32'(m_t));
        check("mtr_off", 32'(motors_off), 32'(m_off));
    endtask

    task automatic model_reset();
        m_p   = '0;
        m_r   = '0;
        m_y   = '0;
        m_t   = '0;
        m_off = 1'b1;
    endtask

    task automatic check_reset_outs();
        check("rst_clr", 32'(u_if.clr_cmd_rdy), 0);
        check("rst_snd", 32'(u_if.snd_resp), 0);
        check("rst_resp", 32'(u_if.resp), 0);
        check("rst_strt", 32'(strt_cal), 0);
        check("rst_inert", 32'(inertial_cal), 0);
        check_model();
    endtask

    task automatic wait_snd(output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (u_if.snd_resp) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic release_resp();
        @(negedge clk);
        u_if.resp_sent = 1'b1;
        @(negedge clk);
        u_if.resp_sent = 1'b0;
    endtask

    task automatic present(input logic [7:0] op, input logic [15:0] d);
        @(negedge clk);
        u_if.cmd_rdy = 1'b1;
        u_if.cmd     = op;
        u_if.data    = d;
        #1;
        check("clr_same_cyc", 32'(u_if.clr_cmd_rdy), 1);
    endtask

    task automatic complete(input logic [7:0] op, input logic [15:0] d,
                            input bit early, input int cal_dly,
                            input int sent_dly, input bit rel);
        int         lat;
        int         k;
        bit         bad;
        logic [7:0] er;
        @(posedge clk);
        #1 u_if.cmd_rdy = 1'b0;
        er = (op >= 8'h02 && op <= 8'h08) ? 8'hA5 : 8'hEE;
        case (op)
            8'h02: m_p = d;
            8'h03: m_r = d;
            8'h04: m_y = d;
            8'h05: m_t = d[8:0];
            8'h06: m_off = 1'b0;
            8'h07: begin
                m_p = '0;
                m_r = '0;
                m_y = '0;
                m_t = '0;
            end
            8'h08: m_off = 1'b1;
            default: ;
        endcase
        if (op == 8'h06) begin
            k = 0;
            while (k < RAMP + 20) begin
                @(negedge clk);
                k++;
                if (k == 1) begin
                    check("mtr_on", 32'(motors_off), 0);
                    if (early) cal_done = 1'b1;
                end
                if (strt_cal) break;
            end
            check("strt_lat", 32'(k), 32'(RAMP + 1));
            check("inert_on", 32'(inertial_cal), 1);
            if (!early) begin
                repeat (cal_dly) @(negedge clk);
                cal_done = 1'b1;
            end
            @(negedge clk);
            cal_done = 1'b0;
            check("inert_off", 32'(inertial_cal), 0);
            wait_snd(lat);
            check("cal_snd_lat", 32'(lat), 1);
        end else begin
            wait_snd(lat);
            check("snd_lat", 32'(lat), 2);
        end
        check("resp", 32'(u_if.resp), 32'(er));
        check_model();
        @(negedge clk);
        check("snd_pulse", 32'(u_if.snd_resp), 0);
        bad = 1'b0;
        repeat (sent_dly) begin
            @(negedge clk);
            if (u_if.snd_resp || u_if.resp !== er || u_if.clr_cmd_rdy)
                bad = 1'b1;
        end
        check("resp_hold", 32'(bad), 0);
        if (rel) release_resp();
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [15:0] d,
                          input bit early, input int cal_dly,
                          input int sent_dly);
        present(op, d);
        complete(op, d, early, cal_dly, sent_dly, 1'b1);
    endtask

    initial begin
        logic [7:0]  op;
        logic [15:0] d;
        bit          bad;
        bit          wd;
        n_chk = 0;
        n_err = 0;
`ifdef CMD_WDOG_EN
        wd = 1'b1;
`else
        wd = 1'b0;
`endif
        rst_n          = 1'b0;
        cal_done       = 1'b0;
        u_if.cmd_rdy   = 1'b0;
        u_if.cmd       = '0;
        u_if.data      = '0;
        u_if.resp_sent = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outs();
        rst_n = 1'b1;

        // stray handshakes in IDLE are ignored
        @(negedge clk);
        u_if.resp_sent = 1'b1;
        cal_done       = 1'b1;
        @(negedge clk);
        u_if.resp_sent = 1'b0;
        cal_done       = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (u_if.snd_resp || inertial_cal) bad = 1'b1;
        end
        check("stray_ignored", 32'(bad), 0);

        do_cmd(8'h02, 16'hFF9C, 1'b0, 0, 20);
        do_cmd(8'h05, 16'hFFFF, 1'b0, 0, 1);
        check("thrst_1ff", 32'(thrst), 32'h1FF);
        do_cmd(8'h03, 16'h1234, 1'b0, 0, 0);
        do_cmd(8'h07, 16'h5555, 1'b0, 0, 2);

        // unknown opcode, then a command queued during WAIT_SENT
        present(8'h3C, 16'hBEEF);
        complete(8'h3C, 16'hBEEF, 1'b0, 0, 2, 1'b0);
        @(negedge clk);
        u_if.cmd_rdy = 1'b1;
        u_if.cmd     = 8'h04;
        u_if.data    = 16'h8001;
        bad = 1'b0;
        repeat (5) begin
            #1;
            if (u_if.clr_cmd_rdy) bad = 1'b1;
            @(negedge clk);
        end
        check("q_not_taken", 32'(bad), 0);
        u_if.resp_sent = 1'b1;
        @(negedge clk);
        u_if.resp_sent = 1'b0;
        #1;
        check("q_clr", 32'(u_if.clr_cmd_rdy), 1);
        complete(8'h04, 16'h8001, 1'b0, 0, 1, 1'b1);

        for (int i = 0; i < 30; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                op = 8'(8'h02 + r);
            end else begin
                op = 8'($urandom);
                if (op >= 8'h02 && op <= 8'h08) op = op | 8'h80;
            end
            if (wd && op == 8'h06) op = 8'h05;
            d = 16'($urandom);
            do_cmd(op, d, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 4)));
        end

        // calibration with a long cal_done delay
        do_cmd(8'h06, 16'h0000, 1'b0, 50, 1);

        // reset in the middle of RAMP
        present(8'h06, 16'h0000);
        @(posedge clk);
        #1 u_if.cmd_rdy = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outs();
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (u_if.snd_resp || strt_cal || inertial_cal) bad = 1'b1;
        end
        check("no_resp_after_rst", 32'(bad), 0);
        do_cmd(8'h03, 16'h7F00, 1'b0, 0, 0);

`ifdef CMD_WDOG_EN
        do_cmd(8'h02, 16'h1234, 1'b0, 0, 0);
        do_cmd(8'h05, 16'h00AB, 1'b0, 0, 0);
        do_cmd(8'h06, 16'h0000, 1'b0, 1, 0);
        bad = 1'b0;
        repeat (24) begin
            @(negedge clk);
            if (u_if.snd_resp) bad = 1'b1;
        end
        check("wd_no_snd", 32'(bad), 0);
        m_p = '0;
        m_r = '0;
        m_y = '0;
        m_t = '0;
        check_model();
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
